picoctrl_seq_core: RTL and testbench

Parametrised successor to the fixed 32-entry PicoCtrl program ROM scheme. It is a single-issue sequencer that fetches one instruction per cycle from an external combinational program memory and evaluates a per-instruction condition on cond_in. It writes immediates into a bank of output registers. Beyond the original write and jump, it adds toggle, timed wait, call/return with a hardware stack, and halt.

---
 rtl/picoctrl_seq_core_if.sv | 23 ++
 rtl/picoctrl_seq_core.sv | 134 +++++++++++++
 tb/tb_picoctrl_seq_core.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/picoctrl_seq_core_if.sv
// Fetch bus and control/status signals of the PicoCtrl sequencer.
// master = sequencer core side, slave = program memory / host side.
interface picoctrl_seq_core_if #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 8,
   parameter int REG_SEL_W = 2
);
   localparam int NUM_REGS = 1 << REG_SEL_W;
   localparam int INSTR_W  = 4 + 3 + REG_SEL_W + DATA_W;

   logic                       run;
   logic [3:0]                 cond_in;
   logic [ADDR_W-1:0]          prog_addr;
   logic [INSTR_W-1:0]         prog_data;
   logic [NUM_REGS*DATA_W-1:0] reg_out;
   logic                       halted;
   logic                       stack_err;

   modport master (input run, cond_in, prog_data,
                   output prog_addr, reg_out, halted, stack_err);
   modport slave  (output run, cond_in, prog_data,
                   input prog_addr, reg_out, halted, stack_err);
endinterface

// File: rtl/picoctrl_seq_core.sv
// Single-issue PicoCtrl sequencer: one instruction per cycle from a combinational
// program memory, with conditional execution, timed wait and a call/return stack.
module picoctrl_seq_core #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 8,
   parameter int REG_SEL_W   = 2,
   parameter int STACK_DEPTH = 4
) (
   input logic                 clk,
   input logic                 reset,
   picoctrl_seq_core_if.master bus
);
   localparam int NUM_REGS = 1 << REG_SEL_W;
   localparam int INSTR_W  = 4 + 3 + REG_SEL_W + DATA_W;
   localparam int SP_W     = $clog2(STACK_DEPTH + 1);
   // Power-of-two storage so the stack pointer indexes it without a width mismatch.
   localparam int STK_N    = 1 << SP_W;

   localparam logic [2:0] OP_NOP = 3'd0, OP_WRITE = 3'd1, OP_JUMP = 3'd2, OP_CALL = 3'd3,
                          OP_RET = 3'd4, OP_WAIT  = 3'd5, OP_TOG  = 3'd6, OP_HALT = 3'd7;

   typedef enum logic [1:0] {S_EXEC, S_STALL, S_HALT} state_t;
   state_t state, state_nxt;

   logic [INSTR_W-1:0]              instr;
   logic [3:0]                      cond;
   logic [2:0]                      op;
   logic [REG_SEL_W-1:0]            sel;
   logic [DATA_W-1:0]               imm;
   logic [ADDR_W-1:0]               pc, pc_nxt, pc_inc;
   logic [DATA_W-1:0]               wait_cnt, wait_nxt, wr_val;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [ADDR_W-1:0]               stk [STK_N];
   logic [SP_W-1:0]                 sp, sp_dec;
   logic cond_true, stk_full, stk_empty, wait_last;
   logic wr_en, push, pop, err_set;

   assign instr      = bus.prog_data;
   assign {cond, op, sel, imm} = instr;
   assign cond_true  = ~cond[3] | (bus.cond_in[cond[1:0]] == cond[2]);
   assign pc_inc     = pc + 1'b1;
   assign sp_dec     = sp - 1'b1;
   assign stk_full   = (sp == SP_W'(STACK_DEPTH));
   assign stk_empty  = (sp == '0);
   assign wait_last  = (wait_cnt == DATA_W'(1));

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= S_EXEC;
      else       state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_EXEC:
            if (bus.run && cond_true)
               case (op)
                  OP_CALL: if (stk_full)   state_nxt = S_HALT;
                  OP_RET:  if (stk_empty)  state_nxt = S_HALT;
                  OP_WAIT: if (imm != '0)  state_nxt = S_STALL;
                  OP_HALT:                 state_nxt = S_HALT;
                  default: ;
               endcase
         S_STALL: if (bus.run && wait_last) state_nxt = S_EXEC;
         default: ;
      endcase
   end

   always_comb begin
      pc_nxt   = pc;
      wait_nxt = wait_cnt;
      wr_en    = 1'b0;
      wr_val   = imm;
      push     = 1'b0;
      pop      = 1'b0;
      err_set  = 1'b0;
      case (state)
         S_EXEC:
            if (bus.run) begin
               if (!cond_true) pc_nxt = pc_inc;
               else
                  case (op)
                     OP_NOP:   pc_nxt = pc_inc;
                     OP_WRITE: begin wr_en = 1'b1; pc_nxt = pc_inc; end
                     OP_JUMP:  pc_nxt = imm[ADDR_W-1:0];
                     OP_CALL:
                        if (stk_full) err_set = 1'b1;
                        else begin push = 1'b1; pc_nxt = imm[ADDR_W-1:0]; end
                     OP_RET:
                        if (stk_empty) err_set = 1'b1;
                        else begin pop = 1'b1; pc_nxt = stk[sp_dec]; end
                     OP_WAIT:
                        if (imm == '0) pc_nxt = pc_inc;
                        else           wait_nxt = imm;
                     OP_TOG: begin
                        wr_en  = 1'b1;
                        wr_val = regs[sel] ^ imm;
                        pc_nxt = pc_inc;
                     end
                     default: ;
                  endcase
            end
         S_STALL:
            if (bus.run) begin
               if (wait_last) begin pc_nxt = pc_inc; wait_nxt = '0; end
               else           wait_nxt = wait_cnt - 1'b1;
            end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc            <= '0;
         wait_cnt      <= '0;
         regs          <= '0;
         sp            <= '0;
         bus.stack_err <= 1'b0;
      end else begin
         pc       <= pc_nxt;
         wait_cnt <= wait_nxt;
         if (wr_en)   regs[sel]     <= wr_val;
         if (push)    sp            <= sp + 1'b1;
         if (pop)     sp            <= sp_dec;
         if (err_set) bus.stack_err <= 1'b1;
      end

   // Stack contents need no reset: sp gates every read.
   always_ff @(posedge clk)
      if (push) stk[sp] <= pc_inc;

   assign bus.prog_addr = pc;
   assign bus.reg_out   = regs;
   assign bus.halted    = (state == S_HALT);
endmodule

// File: tb/tb_picoctrl_seq_core.sv
// Bench for picoctrl_seq_core: single-instruction vector table, directed
// multi-cycle sequences, and random programs against an instruction-level model.
module tb_picoctrl_seq_core;
  localparam int AW = 5, DW = 8, SW = 2, IW = 17;
  localparam logic [2:0] O_NOP = 3'd0, O_WR = 3'd1, O_JMP = 3'd2, O_CALL = 3'd3,
                         O_RET = 3'd4, O_WAIT = 3'd5, O_TOG = 3'd6, O_HLT = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  picoctrl_seq_core_if #(.ADDR_W(AW), .DATA_W(DW), .REG_SEL_W(SW)) bus ();
  logic [IW-1:0] mem [32];
  assign bus.prog_data = mem[bus.prog_addr];

  picoctrl_seq_core #(.ADDR_W(AW), .DATA_W(DW), .REG_SEL_W(SW), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int total = 0, bad = 0;

  typedef struct {
    string nm; logic [3:0] c; logic [2:0] op; logic [1:0] sel; logic [7:0] imm;
    logic [3:0] cin; logic [4:0] pc; logic [31:0] r; logic h; logic e;
  } vec_t;
  vec_t vt [15];

  function automatic logic [IW-1:0] mk(logic [3:0] c, logic [2:0] op, logic [1:0] sel, logic [7:0] imm);
    return {c, op, sel, imm};
  endfunction

  function automatic logic [38:0] st(logic [4:0] pc, logic [31:0] r, logic h, logic e);
    return {pc, r, h, e};
  endfunction

  function automatic logic [38:0] snap();
    return {bus.prog_addr, bus.reg_out, bus.halted, bus.stack_err};
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = mk(4'h0, O_NOP, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    bus.cond_in = 4'h0;
    reset = 1'b1;
    #3;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---- instruction-level reference model ----
  int m_pc, m_stall;
  logic [7:0] m_r [4];
  int m_stk [$];
  bit m_h, m_e;

  task automatic m_reset();
    m_pc = 0; m_stall = 0; m_h = 0; m_e = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_stk.delete();
  endtask

  task automatic m_step(bit rn, logic [3:0] cin);
    logic [IW-1:0] ins; logic [3:0] c; logic [2:0] op; logic [1:0] sel; logic [7:0] imm;
    bit t;
    if (m_h || !rn) return;
    if (m_stall > 0) begin
      m_stall--;
      if (m_stall == 0) m_pc = (m_pc + 1) % 32;
      return;
    end
    ins = mem[m_pc];
    {c, op, sel, imm} = ins;
    t = !c[3] || (cin[c[1:0]] == c[2]);
    if (!t) begin m_pc = (m_pc + 1) % 32; return; end
    case (op)
      O_NOP:  m_pc = (m_pc + 1) % 32;
      O_WR:   begin m_r[sel] = imm; m_pc = (m_pc + 1) % 32; end
      O_JMP:  m_pc = imm % 32;
      O_CALL: if (m_stk.size() == 4) begin m_h = 1; m_e = 1; end
              else begin m_stk.push_back((m_pc + 1) % 32); m_pc = imm % 32; end
      O_RET:  if (m_stk.size() == 0) begin m_h = 1; m_e = 1; end
              else m_pc = m_stk.pop_back();
      O_WAIT: if (imm == 0) m_pc = (m_pc + 1) % 32; else m_stall = imm;
      O_TOG:  begin m_r[sel] = m_r[sel] ^ imm; m_pc = (m_pc + 1) % 32; end
      default: m_h = 1;
    endcase
  endtask

  function automatic logic [38:0] m_snap();
    return {5'(m_pc), m_r[3], m_r[2], m_r[1], m_r[0], m_h, m_e};
  endfunction

  // WAIT 3 at pc=2: count samples at pc 2, optionally with run dropped 2 cycles.
  task automatic wait_test(bit drop);
    int n;
    clear_mem();
    mem[2] = mk(4'b1100, O_WAIT, 2'd0, 8'd3);
    do_reset();
    bus.run = 1'b1;
    bus.cond_in = 4'b0001;
    cyc(); cyc();
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.prog_addr != 5'd2) break;
      n++;
      if (n >= 2) bus.cond_in = 4'b0000;
      if (drop && n == 2) bus.run = 1'b0;
      if (drop && n == 4) bus.run = 1'b1;
      cyc();
    end
    check(drop ? "wait_run_drop_len" : "wait_len", n, drop ? 6 : 4);
    check("wait_after_pc", bus.prog_addr, 3);
  endtask

  initial begin
    bus.run = 1'b0;
    bus.cond_in = 4'h0;
    clear_mem();

    vt[0]  = '{"v_nop",      4'h0,    O_NOP,  2'd0, 8'h00, 4'h0,    5'd1,  32'h0,        1'b0, 1'b0};
    vt[1]  = '{"v_write",    4'h0,    O_WR,   2'd1, 8'hA5, 4'h0,    5'd1,  32'h0000A500, 1'b0, 1'b0};
    vt[2]  = '{"v_jmp_f",    4'b1101, O_JMP,  2'd0, 8'h05, 4'b0000, 5'd1,  32'h0,        1'b0, 1'b0};
    vt[3]  = '{"v_jmp_t",    4'b1101, O_JMP,  2'd0, 8'h05, 4'b0010, 5'd5,  32'h0,        1'b0, 1'b0};
    vt[4]  = '{"v_pol0_t",   4'b1011, O_JMP,  2'd0, 8'h1C, 4'b0000, 5'd28, 32'h0,        1'b0, 1'b0};
    vt[5]  = '{"v_pol0_f",   4'b1011, O_JMP,  2'd0, 8'h1C, 4'b1000, 5'd1,  32'h0,        1'b0, 1'b0};
    vt[6]  = '{"v_call",     4'h0,    O_CALL, 2'd0, 8'h0A, 4'h0,    5'd10, 32'h0,        1'b0, 1'b0};
    vt[7]  = '{"v_ret_empty",4'h0,    O_RET,  2'd0, 8'h00, 4'h0,    5'd0,  32'h0,        1'b1, 1'b1};
    vt[8]  = '{"v_halt",     4'h0,    O_HLT,  2'd0, 8'h00, 4'h0,    5'd0,  32'h0,        1'b1, 1'b0};
    vt[9]  = '{"v_toggle",   4'h0,    O_TOG,  2'd2, 8'h3C, 4'h0,    5'd1,  32'h003C0000, 1'b0, 1'b0};
    vt[10] = '{"v_wait0",    4'h0,    O_WAIT, 2'd0, 8'h00, 4'h0,    5'd1,  32'h0,        1'b0, 1'b0};
    vt[11] = '{"v_wait5",    4'h0,    O_WAIT, 2'd0, 8'h05, 4'h0,    5'd0,  32'h0,        1'b0, 1'b0};
    vt[12] = '{"v_jmp_hi",   4'h0,    O_JMP,  2'd3, 8'hE3, 4'h0,    5'd3,  32'h0,        1'b0, 1'b0};
    vt[13] = '{"v_cond0111", 4'b0111, O_WR,   2'd3, 8'h11, 4'h0,    5'd1,  32'h11000000, 1'b0, 1'b0};
    vt[14] = '{"v_wr_false", 4'b1100, O_WR,   2'd0, 8'h99, 4'h0,    5'd1,  32'h0,        1'b0, 1'b0};

    do_reset();
    check("reset_state", snap(), st(5'd0, 32'h0, 1'b0, 1'b0));

    for (int i = 0; i < 15; i++) begin
      clear_mem();
      mem[0] = mk(vt[i].c, vt[i].op, vt[i].sel, vt[i].imm);
      do_reset();
      bus.cond_in = vt[i].cin;
      bus.run = 1'b1;
      cyc();
      check(vt[i].nm, snap(), st(vt[i].pc, vt[i].r, vt[i].h, vt[i].e));
    end

    // write then halt; halted state ignores run and prog_data
    clear_mem();
    mem[0] = mk(4'h0, O_WR, 2'd1, 8'hA5);
    mem[1] = mk(4'h0, O_HLT, 2'd0, 8'h00);
    do_reset();
    bus.run = 1'b1;
    cyc();
    check("wh_write", snap(), st(5'd1, 32'h0000A500, 1'b0, 1'b0));
    cyc();
    check("wh_halt", snap(), st(5'd1, 32'h0000A500, 1'b1, 1'b0));
    mem[1] = mk(4'h0, O_WR, 2'd0, 8'h77);
    for (int k = 0; k < 20; k++) begin
      bus.run = k[0];
      cyc();
      check("wh_frozen", snap(), st(5'd1, 32'h0000A500, 1'b1, 1'b0));
    end

    wait_test(1'b0);
    wait_test(1'b1);

    // four nested calls then four returns
    begin
      int exp_pc [9] = '{4, 8, 12, 16, 13, 9, 5, 1, 1};
      clear_mem();
      mem[0]  = mk(4'h0, O_CALL, 2'd0, 8'd4);
      mem[4]  = mk(4'h0, O_CALL, 2'd0, 8'd8);
      mem[8]  = mk(4'h0, O_CALL, 2'd0, 8'd12);
      mem[12] = mk(4'h0, O_CALL, 2'd0, 8'd16);
      mem[16] = mk(4'h0, O_RET, 2'd0, 8'd0);
      mem[13] = mk(4'h0, O_RET, 2'd0, 8'd0);
      mem[9]  = mk(4'h0, O_RET, 2'd0, 8'd0);
      mem[5]  = mk(4'h0, O_RET, 2'd0, 8'd0);
      mem[1]  = mk(4'h0, O_HLT, 2'd0, 8'd0);
      do_reset();
      bus.run = 1'b1;
      for (int k = 0; k < 9; k++) begin
        cyc();
        check("callret_pc", bus.prog_addr, exp_pc[k]);
      end
      check("callret_end", {bus.halted, bus.stack_err}, 2'b10);
    end

    // fifth call overflows
    clear_mem();
    for (int k = 0; k < 5; k++) mem[4*k] = mk(4'h0, O_CALL, 2'd0, 8'(4*k + 4));
    do_reset();
    bus.run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("ovf_pc", bus.prog_addr, 4*k + 4);
    end
    cyc();
    check("ovf_err", snap(), st(5'd16, 32'h0, 1'b1, 1'b1));

    // toggle twice, then NOP run to wrap
    clear_mem();
    mem[0] = mk(4'h0, O_WR, 2'd0, 8'h0F);
    mem[1] = mk(4'h0, O_TOG, 2'd0, 8'hFF);
    mem[2] = mk(4'h0, O_TOG, 2'd0, 8'hFF);
    do_reset();
    bus.run = 1'b1;
    cyc(); check("tog_init", bus.reg_out[7:0], 8'h0F);
    cyc(); check("tog_1", bus.reg_out[7:0], 8'hF0);
    cyc(); check("tog_2", bus.reg_out[7:0], 8'h0F);
    for (int k = 0; k < 40 && bus.prog_addr != 5'd31; k++) cyc();
    check("wrap_reach31", bus.prog_addr, 31);
    cyc();
    check("wrap_zero", bus.prog_addr, 0);

    // async reset in the middle of a WAIT inside a call
    clear_mem();
    mem[0] = mk(4'h0, O_WR, 2'd2, 8'h5A);
    mem[1] = mk(4'h0, O_CALL, 2'd0, 8'd3);
    mem[3] = mk(4'h0, O_WAIT, 2'd0, 8'd10);
    do_reset();
    bus.run = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("rst_pre", snap(), st(5'd3, 32'h005A0000, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1 check("rst_async", snap(), st(5'd0, 32'h0, 1'b0, 1'b0));
    mem[0] = mk(4'h0, O_RET, 2'd0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("rst_stack_clr", snap(), st(5'd0, 32'h0, 1'b1, 1'b1));

    // random programs against the model
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 32; i++) begin
        logic [3:0] c; logic [2:0] op; logic [7:0] imm;
        c  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 7)) : {1'b1, 3'($urandom)};
        op = ($urandom_range(0, 99) < 3) ? O_HLT : 3'($urandom_range(0, 6));
        imm = (op == O_WAIT) ? 8'($urandom_range(0, 4)) : 8'($urandom);
        mem[i] = mk(c, op, 2'($urandom), imm);
      end
      do_reset();
      m_reset();
      check("rnd_reset", snap(), m_snap());
      for (int k = 0; k < 80; k++) begin
        bus.run = ($urandom_range(0, 99) < 85);
        bus.cond_in = 4'($urandom);
        m_step(bus.run, bus.cond_in);
        cyc();
        check("rnd_step", snap(), m_snap());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
